// File: rtl/vga_tile_fetch.sv
// Tile-mapped VGA pixel fetch: map lookup, then bitmap lookup, then a registered RGB pixel with aligned syncs.
// Latency: a pixel captured on one pix_en appears on R/G/B/hSync/vSync after the following pix_en.
// Backpressure: none; a pix_en that arrives during the map fetch is dropped and latches the sticky overrun flag.
module vga_tile_fetch #(
    parameter logic [11:0] MAP_BASE = 12'h000,
    parameter logic [11:0] BMP_BASE = 12'h400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic [9:0]  col,
    input  logic [8:0]  row,
    input  logic        active,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [11:0] mem_addr,
    input  logic [8:0]  mem_data,
    output logic        R,
    output logic        G,
    output logic        B,
    output logic        hSync,
    output logic        vSync,
    output logic        overrun
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAP  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] addr_q, addr_d;
    logic [3:0]  sc_q, sc_d;
    logic [3:0]  sr_q, sr_d;
    logic        act_q, act_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        r_q, r_d;
    logic        g_q, g_d;
    logic        b_q, b_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        ovr_q, ovr_d;

    logic [4:0]  sx;
    logic [3:0]  sy;
    logic [3:0]  tile;
    logic [11:0] map_addr;
    logic [11:0] bmp_addr;
    logic [2:0]  field;
    logic        capture;

    // Pixel bit 0 of col/row only selects within a 2x2 screen block.
    logic unused_lsbs;
    assign unused_lsbs = col[0] ^ row[0];

    function automatic logic [2:0] div3(input logic [3:0] v);
        if (v >= 4'd15)      return 3'd5;
        else if (v >= 4'd12) return 3'd4;
        else if (v >= 4'd9)  return 3'd3;
        else if (v >= 4'd6)  return 3'd2;
        else if (v >= 4'd3)  return 3'd1;
        else                 return 3'd0;
    endfunction

    function automatic logic [1:0] mod3(input logic [3:0] v);
        case (v)
            4'd0, 4'd3, 4'd6, 4'd9, 4'd12, 4'd15: return 2'd0;
            4'd1, 4'd4, 4'd7, 4'd10, 4'd13:       return 2'd1;
            default:                              return 2'd2;
        endcase
    endfunction

    always_comb begin
        sx       = col[9:5];
        sy       = row[8:5];
        tile     = mem_data[3:0];
        map_addr = MAP_BASE + {8'd0, sy} * 12'd20 + {7'd0, sx};
        bmp_addr = BMP_BASE + {8'd0, tile} * 12'd96 + {8'd0, sr_q} * 12'd6
                 + {9'd0, div3(sc_q)};
        case (mod3(sc_q))
            2'd0:    field = mem_data[8:6];
            2'd1:    field = mem_data[5:3];
            default: field = mem_data[2:0];
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sc_d    = sc_q;
        sr_d    = sr_q;
        act_d   = act_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        ovr_d   = ovr_q;
        capture = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pix_en) begin
                    capture = 1'b1;
                end
            end
            S_MAP: begin
                addr_d  = bmp_addr;
                state_d = S_HOLD;
                if (pix_en) begin
                    ovr_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (pix_en) begin
                    // Bitmap word is still on mem_data; retire the previous pixel as the next one is captured.
                    r_d     = act_q & field[2];
                    g_d     = act_q & field[1];
                    b_d     = act_q & field[0];
                    hsync_d = hs_q;
                    vsync_d = vs_q;
                    capture = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (capture) begin
            sc_d    = col[4:1];
            sr_d    = row[4:1];
            act_d   = active;
            hs_d    = hsync_in;
            vs_d    = vsync_in;
            addr_d  = map_addr;
            state_d = S_MAP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= 12'd0;
            sc_q    <= 4'd0;
            sr_q    <= 4'd0;
            act_q   <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            r_q     <= 1'b0;
            g_q     <= 1'b0;
            b_q     <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sc_q    <= sc_d;
            sr_q    <= sr_d;
            act_q   <= act_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            ovr_q   <= ovr_d;
        end
    end

    assign mem_addr = addr_q;
    assign R        = r_q;
    assign G        = g_q;
    assign B        = b_q;
    assign hSync    = hsync_q;
    assign vSync    = vsync_q;
    assign overrun  = ovr_q;

endmodule

// File: doc/vga_tile_fetch.md
VGA_TILE_FETCH -- requirements
Module: vga_tile_fetch

Interface
REQ-001 Parameters (name, default, meaning):
- MAP_BASE, 12'h000, base address of the 20x15 tile map.
- BMP_BASE, 12'h400, base address of the 16-entry tile bitmap table.

REQ-002 Ports (name  direction  width  meaning):
- clk  in  1  the 50 MHz system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- pix_en  in  1  one-cycle pixel strobe from the timing generator; its period is at least 2 clk cycles.
- col  in  10  current screen column, 0..639 when active.
- row  in  9  current screen row, 0..479 when active.
- active  in  1  visible-region flag.
- hsync_in  in  1  raw horizontal sync (active-low).
- vsync_in  in  1  raw vertical sync (active-low).
- mem_addr  out  12  read address to the VGA memory, registered.
- mem_data  in  9  read data; valid on the clk edge after mem_addr changes.
- R, G, B  out  1 each  registered pixel colour.
- hSync, vSync  out  1 each  syncs delayed to align with R/G/B.
- overrun  out  1  sticky pixel-strobe protocol error flag.

Function
REQ-003 The block SHALL implement a 3-state machine: S_IDLE, S_MAP and S_HOLD.
REQ-004 In S_IDLE, when pix_en=1, the block SHALL:
- capture col, row, active, hsync_in and vsync_in into stage registers;
- drive mem_addr = MAP_BASE + sy*20 + sx, where sx = col[9:5] and sy = row[8:5];
- go to S_MAP.
REQ-005 In S_MAP (1 cycle, unconditional), the block SHALL:
- take tile = mem_data[3:0];
- drive mem_addr = BMP_BASE + tile*96 + sr*6 + sc/3, where sc = col[4:1] and sr = row[4:1] of the captured pixel;
- go to S_HOLD.
REQ-006 In S_HOLD, mem_addr SHALL hold its value; when pix_en=1, the block SHALL in the same edge:
- register the output pixel (REQ-007);
- register hSync/vSync from the stage registers;
- capture the new pixel and issue its map address (as in REQ-004);
- go to S_MAP.
REQ-007 Output pixel field selection SHALL be: sc%3=0 -> mem_data[8:6]; sc%3=1 -> mem_data[5:3]; sc%3=2 -> mem_data[2:0]. Within the selected field, R=MSB, G=middle bit, B=LSB.
REQ-008 When the captured active=0, R/G/B SHALL be 0 regardless of mem_data; hSync/vSync SHALL still pass through.
REQ-009 Latency: a pixel captured on pix_en edge k SHALL appear on R/G/B/hSync/vSync after pix_en edge k+1. Between strobes the outputs SHALL hold.
REQ-010 The first pix_en after reset SHALL only capture; the outputs SHALL keep their reset values until the second pix_en.
REQ-011 All address arithmetic SHALL be 12-bit unsigned. The maximum address (tile 15, sr 15, sc 15) is BMP_BASE+0x5FF; any overflow beyond 12 bits SHALL wrap.
REQ-012 pix_en=1 while in S_MAP SHALL be ignored (no capture, no output update) and SHALL set overrun=1. overrun SHALL stay at 1 until reset.

Reset
REQ-013 While reset=1 at any time, including mid-fetch, the block SHALL immediately force: state=S_IDLE, mem_addr=0, R=G=B=0, hSync=vSync=1, overrun=0, and all stage registers to 0.
REQ-014 After reset deasserts, the block SHALL wait in S_IDLE for the next pix_en. No output SHALL change before the second pix_en.

Verification
REQ-015 The bench SHALL cover these directed scenarios:
- Reset during S_MAP -> next cycle: mem_addr=0x000, RGB=000, hSync=vSync=1, overrun=0.
- col=37, row=70, active=1 -> mem_addr=0x029. With mem_data=0x003 -> mem_addr=0x532. With mem_data=9'b000000110 -> after the next pix_en, R=1, G=1, B=0.
- col=639, row=479, map data=15 -> mem_addr sequence 0x12B then 0x9FF. With mem_data=9'b011000000 -> R=0, G=1, B=1.
- active=0 with mem_data=0x1FF throughout -> RGB=000; hSync/vSync follow hsync_in/vsync_in one strobe later.
- hsync_in=0 for exactly one strobe k -> hSync=0 for exactly one strobe interval, starting after pix_en k+1.
- pix_en asserted two consecutive cycles -> the second is ignored, overrun=1 and remains 1 over 100 further strobes, and the pixel pipeline is otherwise unaffected.
